// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out LSB-first, DIV clocks per bit, followed by GAP idle bit-periods.
module piso_tx #(
  parameter int   WIDTH    = 4,
  parameter int   DIV      = 1,
  parameter int   GAP      = 0,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             bit_stb,
  output logic             word_done,
  output logic             busy
);

  localparam int BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW       = $clog2(DIV) + 1;
  localparam int GAP_CLKS = GAP * DIV;
  localparam int GW       = $clog2(GAP_CLKS) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  // Only reachable when GAP > 0; the GAP == 0 value is never compared against.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             so_q, so_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      so_q       <= IDLE_LVL;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      in_ready_q <= in_ready_d;
      so_q       <= so_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    in_ready_d = in_ready_q;
    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          shreg_d    = in_data;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          in_ready_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_stb) begin
          shreg_d   = {IDLE_LVL, shreg_q[WIDTH-1:1]};
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d    = S_IDLE;
              in_ready_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d  = '0;
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // so is registered from the next state so it is glitch-free and idles outside SHIFT.
    so_d = (state_d == S_SHIFT) ? shreg_d[0] : IDLE_LVL;
  end

  always_comb begin
    bit_stb   = (state_q == S_SHIFT) && (div_cnt_q == DIV_LAST);
    word_done = bit_stb && (bit_cnt_q == BIT_LAST);
    busy      = (state_q != S_IDLE);
    in_ready  = in_ready_q;
    so        = so_q;
  end

endmodule
